// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared widths, opcodes and divider state type for the EX stage
// Purpose: single source of bus widths, aluop/alusel encodings and the divider
// FSM state enum used by ex_stage, div_unit, ex_stage_if and the bench.
package ex_stage_pkg;

  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  // Quotient bits produced, one per cycle in the ON state.
  localparam int DIV_STEPS = 32;

  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [AluOpBus-1:0] EXE_SLLV_OP = 8'b0000_0100;
  localparam logic [AluOpBus-1:0] EXE_SRLV_OP = 8'b0000_0110;
  localparam logic [AluOpBus-1:0] EXE_SRAV_OP = 8'b0000_0111;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP = 8'b0001_0000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP = 8'b0001_0001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP = 8'b0001_0010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP = 8'b0001_0011;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_END  = 2'd3
  } div_state_e;

  function automatic logic is_div_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs and EX outputs of the execute stage
// Purpose: bundles the decoded instruction fields entering EX and the
// forwarding/result/HI-LO signals leaving it.
// Modports: master = upstream/pipeline side (drives *_i, reads *_o),
//           slave  = ex_stage (reads *_i, drives *_o).
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [AluOpBus-1:0]   aluop_i;
  logic [AluSelBus-1:0]  alusel_i;
  logic [RegBus-1:0]     reg1_i;
  logic [RegBus-1:0]     reg2_i;
  logic [RegAddrBus-1:0] wd_i;
  logic                  wreg_i;

  logic [RegAddrBus-1:0] wd_o;
  logic                  wreg_o;
  logic [RegBus-1:0]     wdata_o;
  logic                  stallreq_o;
  logic [RegBus-1:0]     hi_o;
  logic [RegBus-1:0]     lo_o;

  modport master (
    output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
  );

endinterface

// File: rtl/ex_stage_div.sv
// rtl/ex_stage_div.sv - 32-step restoring divider for DIV/DIVU
// Purpose: multi-cycle divider FSM (IDLE, ZERO, ON, END).
// Ports: clk, rst (sync, active-high); start (div op present), signed_div,
//        annul (op withdrawn, abandon work), opdata1 (dividend),
//        opdata2 (divisor); result = {remainder, quotient} valid while
//        ready; busy while ON or ZERO.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [RegBus-1:0] opdata1,
  input  logic [RegBus-1:0] opdata2,
  output logic [63:0]       result,
  output logic              ready,
  output logic              busy
);

  div_state_e state, state_nxt;
  logic [4:0]        cnt;
  logic [RegBus-1:0] rem;
  logic [RegBus-1:0] quot;     // holds the dividend, shifted out as quotient bits shift in
  logic [RegBus-1:0] divisor;
  logic              neg_quot;
  logic              neg_rem;
  logic [RegBus:0]   trial;

  // Partial remainder < divisor, so {rem, next bit} fits in 33 bits and
  // trial[32] set means the subtraction went negative (restore).
  assign trial = {rem, quot[RegBus-1]} - {1'b0, divisor};

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start) state_nxt = (opdata2 == ZeroWord) ? DIV_ZERO : DIV_ON;
      DIV_ZERO: state_nxt = annul ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (annul)                              state_nxt = DIV_IDLE;
        else if (cnt == 5'(DIV_STEPS - 1))      state_nxt = DIV_END;
      end
      DIV_END:  state_nxt = DIV_IDLE;
      default:  state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && opdata2 != ZeroWord) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= (signed_div && opdata1[RegBus-1]) ? -opdata1 : opdata1;
            divisor  <= (signed_div && opdata2[RegBus-1]) ? -opdata2 : opdata2;
            neg_quot <= signed_div && (opdata1[RegBus-1] ^ opdata2[RegBus-1]);
            neg_rem  <= signed_div && opdata1[RegBus-1];
          end
        end
        DIV_ZERO: begin
          rem      <= '0;
          quot     <= '0;
          neg_quot <= 1'b0;
          neg_rem  <= 1'b0;
        end
        DIV_ON: begin
          if (!trial[RegBus]) begin
            rem  <= trial[RegBus-1:0];
            quot <= {quot[RegBus-2:0], 1'b1};
          end else begin
            rem  <= {rem[RegBus-2:0], quot[RegBus-1]};
            quot <= {quot[RegBus-2:0], 1'b0};
          end
          cnt <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  assign result = {(neg_rem ? -rem : rem), (neg_quot ? -quot : quot)};
  assign ready  = (state == DIV_END);
  assign busy   = (state == DIV_ON) || (state == DIV_ZERO);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS32 execute stage: logic/shift/move ALU, HI/LO, divider stall
// Purpose: combinational result for single-cycle ops, owner of HI/LO,
// stall request while DIV/DIVU is in progress.
// Ports: clk, rst (sync, active-high); ex (ex_stage_if.slave):
//        aluop_i/alusel_i/reg1_i/reg2_i/wd_i/wreg_i in,
//        wd_o/wreg_o/wdata_o forwarding bus, stallreq_o, hi_o/lo_o out.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  ex
);

  logic              is_div;
  logic              is_mt;
  logic              stall;
  logic [RegBus-1:0] hi_q, lo_q;
  logic [63:0]       div_result;
  logic              div_ready, div_busy;
  logic [RegBus-1:0] logic_res, shift_res, move_res, alu_res;
  logic [4:0]        shamt;

  assign is_div = is_div_op(ex.aluop_i);
  assign is_mt  = (ex.aluop_i == EXE_MTHI_OP) || (ex.aluop_i == EXE_MTLO_OP);
  assign shamt  = ex.reg1_i[4:0];

  div_unit u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .signed_div (ex.aluop_i == EXE_DIV_OP),
    .annul      (!is_div),
    .opdata1    (ex.reg1_i),
    .opdata2    (ex.reg2_i),
    .result     (div_result),
    .ready      (div_ready),
    .busy       (div_busy)
  );

  // END is the one unstalled cycle that lets the pipeline advance past the DIV.
  assign stall = is_div && !div_ready;

  always_comb begin
    logic_res = ZeroWord;
    case (ex.aluop_i)
      EXE_OR_OP:  logic_res = ex.reg1_i | ex.reg2_i;
      EXE_AND_OP: logic_res = ex.reg1_i & ex.reg2_i;
      EXE_XOR_OP: logic_res = ex.reg1_i ^ ex.reg2_i;
      EXE_NOR_OP: logic_res = ~(ex.reg1_i | ex.reg2_i);
      default:    logic_res = ZeroWord;
    endcase
  end

  always_comb begin
    shift_res = ZeroWord;
    case (ex.aluop_i)
      EXE_SLL_OP, EXE_SLLV_OP: shift_res = ex.reg2_i << shamt;
      EXE_SRL_OP, EXE_SRLV_OP: shift_res = ex.reg2_i >> shamt;
      EXE_SRA_OP, EXE_SRAV_OP: shift_res = $unsigned($signed(ex.reg2_i) >>> shamt);
      default:                 shift_res = ZeroWord;
    endcase
  end

  always_comb begin
    move_res = ZeroWord;
    case (ex.aluop_i)
      EXE_MFHI_OP: move_res = hi_q;
      EXE_MFLO_OP: move_res = lo_q;
      default:     move_res = ZeroWord;
    endcase
  end

  always_comb begin
    alu_res = ZeroWord;
    case (ex.alusel_i)
      EXE_RES_LOGIC: alu_res = logic_res;
      EXE_RES_SHIFT: alu_res = shift_res;
      EXE_RES_MOVE:  alu_res = move_res;
      default:       alu_res = ZeroWord;
    endcase
  end

  always_comb begin
    ex.wd_o       = ex.wd_i;
    ex.wreg_o     = ex.wreg_i;
    ex.wdata_o    = alu_res;
    ex.stallreq_o = stall;
    if (rst) begin
      ex.wd_o       = '0;
      ex.wreg_o     = WriteDisable;
      ex.wdata_o    = ZeroWord;
      ex.stallreq_o = 1'b0;
    end else if (is_div) begin
      ex.wreg_o  = WriteDisable;
      ex.wdata_o = ZeroWord;
    end else if (is_mt) begin
      ex.wreg_o  = WriteDisable;
    end
  end

  // Divider completion has priority; MTHI/MTLO only land when nothing is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (div_ready) begin
      hi_q <= div_result[63:32];
      lo_q <= div_result[31:0];
    end else if (!stall && !div_busy) begin
      if (ex.aluop_i == EXE_MTHI_OP) hi_q <= ex.reg1_i;
      if (ex.aluop_i == EXE_MTLO_OP) lo_q <= ex.reg1_i;
    end
  end

  assign ex.hi_o = hi_q;
  assign ex.lo_o = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_data;
    logic [4:0]  exp_wd;
    logic        exp_wreg;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          stalls;
  } div_exp_t;

  vec_t     vecs[$];
  vec_t     sb[$];
  div_exp_t div_sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    @(posedge clk);
    #1;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = r1;
    bus.reg2_i   = r2;
    bus.wd_i     = wd;
    bus.wreg_i   = wreg;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [4:0] wd, input logic wreg,
                              input logic [31:0] ed, input logic ewreg);
    vec_t v;
    v.aluop = op; v.alusel = sel; v.r1 = r1; v.r2 = r2; v.wd = wd; v.wreg = wreg;
    v.exp_data = ed; v.exp_wd = wd; v.exp_wreg = ewreg;
    return v;
  endfunction

  task automatic run_div(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_stalls);
    div_exp_t e;
    int n;
    div_sb.push_back('{exp_lo, exp_hi, exp_stalls});
    drive(op, EXE_RES_ARITH, a, b, 5'd3, 1'b1);
    n = 0;
    @(negedge clk);
    while (bus.stallreq_o === 1'b1 && n < 200) begin
      check({name, " wreg_o while stalled"}, 32'(bus.wreg_o), 32'd0);
      n++;
      @(negedge clk);
    end
    e = div_sb.pop_front();
    check({name, " stall cycles"}, n, e.stalls);
    check({name, " wreg_o at end"}, 32'(bus.wreg_o), 32'd0);
    check({name, " wdata_o at end"}, bus.wdata_o, 32'd0);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check({name, " LO"}, bus.lo_o, e.lo);
    check({name, " HI"}, bus.hi_o, e.hi);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd5, 1'b1);
    @(negedge clk);
    check("reset wdata_o", bus.wdata_o, 32'd0);
    check("reset wd_o", 32'(bus.wd_o), 32'd0);
    check("reset wreg_o", 32'(bus.wreg_o), 32'd0);
    check("reset stallreq_o", 32'(bus.stallreq_o), 32'd0);
    check("reset hi_o", bus.hi_o, 32'd0);
    check("reset lo_o", bus.lo_o, 32'd0);
    rst = 1'b0;

    vecs.push_back(mk(EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000F0F0, 32'h00000F0F, 5'd5,  1'b1, 32'h0000FFFF, 1'b1));
    vecs.push_back(mk(EXE_AND_OP,  EXE_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd6,  1'b1, 32'h0F000F00, 1'b1));
    vecs.push_back(mk(EXE_XOR_OP,  EXE_RES_LOGIC, 32'hFFFF0000, 32'h0F0F0F0F, 5'd7,  1'b1, 32'hF0F00F0F, 1'b1));
    vecs.push_back(mk(EXE_NOR_OP,  EXE_RES_LOGIC, 32'h00000000, 32'h00000000, 5'd8,  1'b0, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk(EXE_SRA_OP,  EXE_RES_SHIFT, 32'd4,        32'h80000010, 5'd9,  1'b1, 32'hF8000001, 1'b1));
    vecs.push_back(mk(EXE_SRL_OP,  EXE_RES_SHIFT, 32'd4,        32'h80000010, 5'd10, 1'b1, 32'h08000001, 1'b1));
    vecs.push_back(mk(EXE_SLLV_OP, EXE_RES_SHIFT, 32'h24,       32'h00000010, 5'd11, 1'b1, 32'h00000100, 1'b1));
    vecs.push_back(mk(EXE_SLL_OP,  EXE_RES_SHIFT, 32'd31,       32'h00000001, 5'd12, 1'b1, 32'h80000000, 1'b1));
    vecs.push_back(mk(EXE_SRAV_OP, EXE_RES_SHIFT, 32'h21,       32'h7FFFFFFE, 5'd13, 1'b1, 32'h3FFFFFFF, 1'b1));
    vecs.push_back(mk(EXE_SRLV_OP, EXE_RES_SHIFT, 32'h20,       32'h80000000, 5'd14, 1'b1, 32'h80000000, 1'b1));
    vecs.push_back(mk(8'hEE,       EXE_RES_LOGIC, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1'b1, 32'h00000000, 1'b1));
    vecs.push_back(mk(EXE_OR_OP,   EXE_RES_NOP,   32'h12345678, 32'h1,        5'd16, 1'b1, 32'h00000000, 1'b1));
    vecs.push_back(mk(EXE_MFHI_OP, EXE_RES_MOVE,  32'h0,        32'h0,        5'd17, 1'b1, 32'h00000000, 1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].aluop, vecs[i].alusel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
      sb.push_back(vecs[i]);
      @(negedge clk);
      v = sb.pop_front();
      check($sformatf("vec%0d wdata_o", i), bus.wdata_o, v.exp_data);
      check($sformatf("vec%0d wd_o", i), 32'(bus.wd_o), 32'(v.exp_wd));
      check($sformatf("vec%0d wreg_o", i), 32'(bus.wreg_o), 32'(v.exp_wreg));
      check($sformatf("vec%0d stallreq_o", i), 32'(bus.stallreq_o), 32'd0);
    end

    drive(EXE_MTHI_OP, EXE_RES_MOVE, 32'h12345678, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    check("MTHI wreg_o", 32'(bus.wreg_o), 32'd0);
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    check("MFHI wdata_o", bus.wdata_o, 32'h12345678);
    check("MFHI hi_o", bus.hi_o, 32'h12345678);
    check("MFHI wreg_o", 32'(bus.wreg_o), 32'd1);
    drive(EXE_MTLO_OP, EXE_RES_MOVE, 32'hCAFEF00D, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    check("MTLO wreg_o", 32'(bus.wreg_o), 32'd0);
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    check("MFLO wdata_o", bus.wdata_o, 32'hCAFEF00D);
    check("MTLO keeps hi_o", bus.hi_o, 32'h12345678);

    run_div("DIVU 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("DIV -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_div("DIV by 0", EXE_DIV_OP, 32'd55, 32'd0, 32'd0, 32'd0, 2);
    run_div("DIV 100/-7", EXE_DIV_OP, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 33);

    drive(EXE_DIVU_OP, EXE_RES_ARITH, 32'd100, 32'd7, 5'd3, 1'b1);
    repeat (10) @(negedge clk);
    check("pre-reset stallreq_o", 32'(bus.stallreq_o), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid-div reset stallreq_o", 32'(bus.stallreq_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.aluop_i  = EXE_NOP_OP;
    bus.alusel_i = EXE_RES_NOP;
    @(negedge clk);
    check("mid-div reset HI", bus.hi_o, 32'd0);
    check("mid-div reset LO", bus.lo_o, 32'd0);
    run_div("DIVU 9/3", EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    drive(EXE_DIV_OP, EXE_RES_ARITH, 32'd50, 32'd5, 5'd3, 1'b1);
    repeat (5) @(negedge clk);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    check("flush stallreq_o", 32'(bus.stallreq_o), 32'd0);
    repeat (3) @(negedge clk);
    check("flush keeps LO", bus.lo_o, 32'd3);
    check("flush keeps HI", bus.hi_o, 32'd0);
    run_div("DIVU max/1", EXE_DIVU_OP, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
